register_file_16x32: RTL and testbench
======================================

// Module: register_file_16x32
// PURPOSE
//   Read side of the datapath's 32-bit storage: 16 x 32-bit registers with
//   one write port and two registered read ports (A, B) feeding the ALU
//   operand latches. Each word is a load-enabled 32-bit register. Read data
//   is captured on the clock edge, with write-first bypass so a value
//   written in cycle N is visible on a read issued in the same cycle N.
// PARAMETERS
//   WIDTH   32  data width of every register and port
//   DEPTH   16  number of registers
//   AW       4  address width, log2(DEPTH)
// PORTS
//   clk   in   1      clock; all state updates on posedge
//   clr   in   1      synchronous clear, active-low
//   ld    in   1      write enable: 1 = write pw into register rw this edge
//   rw    in   AW     write address
//   pw    in   WIDTH  write data
//   ra    in   AW     read address, port A
//   rb    in   AW     read address, port B
//   pa    out  WIDTH  registered read data, port A
//   pb    out  WIDTH  registered read data, port B
// BEHAVIOUR
//   - All state changes only on posedge clk. No asynchronous paths to state.
//   - Clear: clr==0 sampled at an edge -> all DEPTH registers <= 0, pa <= 0,
//     pb <= 0. Clear overrides ld and reads in that edge (ld ignored).
//     pa/pb read 0 on the edge after clr is released until a new read lands.
//   - Write: clr==1 && ld==1 -> reg[rw] <= pw. ld==0 -> no register changes.
//     All 16 registers are writable; there is no hardwired-zero register.
//   - Read, port A (port B identical with rb/pb), when clr==1:
//       pa <= (ld && rw==ra) ? pw : reg[ra]    // write-first bypass
//     Latency: address presented before edge N -> data on pa after edge N.
//     pa holds its value between edges; it updates every edge (no enable).
//   - ra==rb: both ports return the same value, bypass included.
//   - ra==rw with ld==0: no bypass; the stored value is returned.
//   - Back-to-back writes to the same rw: the last write wins. A read the
//     following cycle returns the most recent value.
//   - Clear in the middle of a write sequence: the write on the clear edge
//     is dropped. The first write after release proceeds normally.
//   - Address inputs are always in range (AW bits index exactly DEPTH words).
//   - Unknown or X inputs: not required to be handled; the bench drives
//     known values.
// TESTING
//   1 Reset: write 32'hFFFF_FFFF to every register; drive clr=0 for one edge,
//     then read all 16 through A and B -> every read returns 32'h0.
//   2 Write/read: ld=1 rw=3 pw=32'h0000_000A; next cycle ld=0 ra=3 rb=3
//     -> pa=pb=32'h0000_000A one edge later.
//   3 Bypass: ld=1 rw=5 pw=32'h0000_000B with ra=5 on the same edge
//     -> pa=32'h0000_000B after that edge, not the old reg[5].
//   4 Hold: reg[7]=32'h0000_000C; ld=0 rw=7 pw=32'hDEAD_BEEF ra=7
//     -> pa stays 32'h0000_000C; a later read of reg[7] is still 0xC.
//   5 Clear beats write: ld=1 rw=2 pw=32'h1234_5678 with clr=0 on the same
//     edge -> a later read of reg[2] returns 32'h0.
//   6 Independence: fill reg[i]=i for i=0..15; sweep ra=i and rb=15-i
//     -> pa=i and pb=15-i, each one edge after its address is presented.

Source files
------------

// File: rtl/register_file_16x32_if.sv
// Bus bundle for the 16x32 register file: one write port and two read ports.
// The master drives addresses, write data and write enable. The slave returns the registered read data.
interface register_file_16x32_if #(
   parameter int WIDTH = 32,
   parameter int AW    = 4
);
   logic             ld;
   logic [AW-1:0]    rw;
   logic [WIDTH-1:0] pw;
   logic [AW-1:0]    ra;
   logic [AW-1:0]    rb;
   logic [WIDTH-1:0] pa;
   logic [WIDTH-1:0] pb;

   modport master (
      output ld, rw, pw, ra, rb,
      input  pa, pb
   );

   modport slave (
      input  ld, rw, pw, ra, rb,
      output pa, pb
   );
endinterface

// File: rtl/register_file_16x32.sv
// 16 x 32-bit register file with one write port and two registered read ports.
// Reads are write-first: a write and a read to the same address on the same edge return the new data.
module register_file_16x32 #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic                  clk,
   input  logic                  clr,
   register_file_16x32_if.slave  bus
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0] wr_sel;
   logic [WIDTH-1:0] pa_q, pa_d;
   logic [WIDTH-1:0] pb_q, pb_d;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
         assign wr_sel[gi] = bus.ld && (bus.rw == AW'(gi));
      end
   endgenerate

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = wr_sel[i] ? bus.pw : mem_q[i];
      end
      // Read from the post-write view so a same-edge write is bypassed to the ports.
      pa_d = mem_d[bus.ra];
      pb_d = mem_d[bus.rb];
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         pa_q <= '0;
         pb_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         pa_q <= pa_d;
         pb_q <= pb_d;
      end
   end

   assign bus.pa = pa_q;
   assign bus.pb = pb_q;

endmodule

// File: tb/tb_register_file_16x32.sv
// Self-checking bench for register_file_16x32: directed vector table, hand sequences,
// and randomized traffic compared against an array-based reference model.
module tb_register_file_16x32;

   logic clk = 1'b0;
   logic clr;
   always #5 clk = ~clk;

   register_file_16x32_if bus ();

   register_file_16x32 dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   typedef struct {
      logic        clr;
      logic        ld;
      logic [3:0]  rw;
      logic [31:0] pw;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [31:0] exp_pa;
      logic [31:0] exp_pb;
   } vec_t;

   vec_t        vecs [11];
   logic [31:0] mdl  [16];
   int          n_total = 0;
   int          n_pass  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Applies one transaction across one clock edge and predicts the read data from the model.
   task automatic step(input logic c, input logic l, input logic [3:0] w, input logic [31:0] d,
                       input logic [3:0] a, input logic [3:0] b,
                       output logic [31:0] epa, output logic [31:0] epb);
      clr    = c;
      bus.ld = l;
      bus.rw = w;
      bus.pw = d;
      bus.ra = a;
      bus.rb = b;
      if (!c) begin
         epa = 32'h0;
         epb = 32'h0;
         for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
      end else begin
         epa = (l && w == a) ? d : mdl[a];
         epb = (l && w == b) ? d : mdl[b];
         if (l) mdl[w] = d;
      end
      @(posedge clk);
      #1;
      $display("t=%0t clr=%b ld=%b rw=%0d pw=%h ra=%0d rb=%0d -> pa=%h pb=%h",
               $time, c, l, w, d, a, b, bus.pa, bus.pb);
   endtask

   initial begin
      logic [31:0] epa, epb;
      logic        c, l;
      logic [3:0]  w, a, b;
      logic [31:0] d;

      vecs[0]  = '{1'b1, 1'b1, 4'd3, 32'h0000_000A, 4'd0, 4'd0, 32'h0,          32'h0};
      vecs[1]  = '{1'b1, 1'b0, 4'd0, 32'h0,          4'd3, 4'd3, 32'h0000_000A, 32'h0000_000A};
      vecs[2]  = '{1'b1, 1'b1, 4'd5, 32'h0000_000B, 4'd5, 4'd3, 32'h0000_000B, 32'h0000_000A};
      vecs[3]  = '{1'b1, 1'b1, 4'd7, 32'h0000_000C, 4'd5, 4'd7, 32'h0000_000B, 32'h0000_000C};
      vecs[4]  = '{1'b1, 1'b0, 4'd7, 32'hDEAD_BEEF, 4'd7, 4'd7, 32'h0000_000C, 32'h0000_000C};
      vecs[5]  = '{1'b1, 1'b0, 4'd0, 32'h0,          4'd7, 4'd5, 32'h0000_000C, 32'h0000_000B};
      vecs[6]  = '{1'b0, 1'b1, 4'd2, 32'h1234_5678, 4'd3, 4'd7, 32'h0,          32'h0};
      vecs[7]  = '{1'b1, 1'b0, 4'd0, 32'h0,          4'd2, 4'd3, 32'h0,          32'h0};
      vecs[8]  = '{1'b1, 1'b1, 4'd2, 32'h0000_0005, 4'd2, 4'd2, 32'h0000_0005, 32'h0000_0005};
      vecs[9]  = '{1'b1, 1'b1, 4'd2, 32'h0000_0006, 4'd0, 4'd0, 32'h0,          32'h0};
      vecs[10] = '{1'b1, 1'b0, 4'd0, 32'h0,          4'd2, 4'd2, 32'h0000_0006, 32'h0000_0006};

      // Power-up clear
      step(1'b0, 1'b0, 4'd0, 32'h0, 4'd0, 4'd0, epa, epb);
      step(1'b0, 1'b0, 4'd0, 32'h0, 4'd0, 4'd0, epa, epb);
      check("reset_pa", bus.pa, 32'h0);
      check("reset_pb", bus.pb, 32'h0);

      // Fill with ones, clear for one edge, then every read must be zero
      for (int i = 0; i < 16; i++)
         step(1'b1, 1'b1, 4'(i), 32'hFFFF_FFFF, 4'd0, 4'd0, epa, epb);
      step(1'b0, 1'b0, 4'd0, 32'h0, 4'd0, 4'd0, epa, epb);
      check("clear_pa", bus.pa, 32'h0);
      check("clear_pb", bus.pb, 32'h0);
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b0, 4'd0, 32'h0, 4'(i), 4'(i), epa, epb);
         check($sformatf("clr_rd_a%0d", i), bus.pa, 32'h0);
         check($sformatf("clr_rd_b%0d", i), bus.pb, 32'h0);
      end

      // Directed table: write/read, bypass, hold, clear-beats-write, last-write-wins
      for (int v = 0; v < 11; v++) begin
         step(vecs[v].clr, vecs[v].ld, vecs[v].rw, vecs[v].pw, vecs[v].ra, vecs[v].rb, epa, epb);
         check($sformatf("vec%0d_pa", v), bus.pa, vecs[v].exp_pa);
         check($sformatf("vec%0d_pb", v), bus.pb, vecs[v].exp_pb);
      end

      // Independence sweep: reg[i]=i, ports read opposite ends
      for (int i = 0; i < 16; i++)
         step(1'b1, 1'b1, 4'(i), 32'(i), 4'd0, 4'd0, epa, epb);
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b0, 4'd0, 32'h0, 4'(i), 4'(15 - i), epa, epb);
         check($sformatf("sweep_pa%0d", i), bus.pa, 32'(i));
         check($sformatf("sweep_pb%0d", i), bus.pb, 32'(15 - i));
      end

      // Randomized traffic with biased address collisions
      for (int k = 0; k < 200; k++) begin
         c = ($urandom_range(0, 19) != 0);
         l = 1'($urandom_range(0, 1));
         w = 4'($urandom_range(0, 15));
         d = $urandom;
         a = ($urandom_range(0, 2) == 0) ? w : 4'($urandom_range(0, 15));
         b = ($urandom_range(0, 2) == 0) ? a : 4'($urandom_range(0, 15));
         step(c, l, w, d, a, b, epa, epb);
         check($sformatf("rand%0d_pa", k), bus.pa, epa);
         check($sformatf("rand%0d_pb", k), bus.pb, epb);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
